// File: rtl/la_program_loader_if.sv
// Bundles the LA-side control inputs and the IRAM/core-side outputs of la_program_loader.
// Latency: none, this is wiring only.
// Backpressure: none; LA inputs have no ready, so the driver must respect the strobe spacing.
// Optional port: checksum, present only when LOADER_CHECKSUM_EN is defined.
interface la_program_loader_if #(
  parameter int ADDR_W = 4,
  parameter int RUN_W  = 16
);
  // LA probe side
  logic              la_load_req;
  logic              la_word_strobe;
  logic [31:0]       la_word;
  logic              la_run_req;
  logic [RUN_W-1:0]  la_run_cycles;
  // IRAM write port, core control and status
  logic              iram_write;
  logic [ADDR_W-1:0] iram_select;
  logic [31:0]       iram_data;
  logic              core_rst_n;
  logic              core_clk_en;
  logic [1:0]        state;
  logic [ADDR_W:0]   words_loaded;
  logic [RUN_W-1:0]  cycles_run;
  logic              err_overflow;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  modport master (
    output la_load_req, la_word_strobe, la_word, la_run_req, la_run_cycles,
    input  iram_write, iram_select, iram_data, core_rst_n, core_clk_en,
           state, words_loaded, cycles_run, err_overflow
`ifdef LOADER_CHECKSUM_EN
         , checksum
`endif
  );

  modport slave (
    input  la_load_req, la_word_strobe, la_word, la_run_req, la_run_cycles,
    output iram_write, iram_select, iram_data, core_rst_n, core_clk_en,
           state, words_loaded, cycles_run, err_overflow
`ifdef LOADER_CHECKSUM_EN
         , checksum
`endif
  );
endinterface

// File: rtl/la_program_loader.sv
// Sequences LA-strobed instruction words into the IRAM, then runs the core for a bounded or free-running span.
// Latency: an LA input edge sampled at edge k acts at edge k+2 (write pulse, state change), all outputs registered.
// Backpressure: none; strobes need >=3 cycle spacing, overflow strobes are dropped and flagged sticky.
// Optional feature: LOADER_CHECKSUM_EN adds a rotate-XOR checksum of committed words.
module la_program_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int RUN_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  la_program_loader_if.slave lp
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_HALT = 2'b11
  } state_t;

  localparam logic [ADDR_W:0]  FULL    = (ADDR_W+1)'(DEPTH);
  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  // LA input samples and registered edge pulses
  logic        load_cur_q, load_prev_q, strb_cur_q, strb_prev_q, run_cur_q, run_prev_q;
  logic        load_rise_q, load_fall_q, strb_rise_q, run_rise_q;
  logic [31:0] word_q;

  // Sequencer state and registered outputs
  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] sel_q, sel_d;
  logic [31:0]       data_q, data_d;
  logic              crst_q, crst_d;
  logic              cen_q, cen_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic [RUN_W-1:0]  cyc_q, cyc_d, cyc_inc;
  logic [RUN_W-1:0]  budget_q, budget_d;
  logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       cs_q, cs_d;
`endif

  // Sample the LA controls once, then turn cur/prev pairs into one-cycle edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cur_q  <= 1'b0;
      load_prev_q <= 1'b0;
      strb_cur_q  <= 1'b0;
      strb_prev_q <= 1'b0;
      run_cur_q   <= 1'b0;
      run_prev_q  <= 1'b0;
      load_rise_q <= 1'b0;
      load_fall_q <= 1'b0;
      strb_rise_q <= 1'b0;
      run_rise_q  <= 1'b0;
      word_q      <= '0;
    end else begin
      load_cur_q  <= lp.la_load_req;
      load_prev_q <= load_cur_q;
      strb_cur_q  <= lp.la_word_strobe;
      strb_prev_q <= strb_cur_q;
      run_cur_q   <= lp.la_run_req;
      run_prev_q  <= run_cur_q;
      load_rise_q <= load_cur_q & ~load_prev_q;
      load_fall_q <= ~load_cur_q & load_prev_q;
      strb_rise_q <= strb_cur_q & ~strb_prev_q;
      run_rise_q  <= run_cur_q & ~run_prev_q;
      // Captured on the detect edge so the write carries the word seen then.
      word_q      <= lp.la_word;
    end
  end

  assign cyc_inc = (cyc_q == RUN_MAX) ? cyc_q : cyc_q + 1'b1;

  // Next state plus next values of every registered output; load edges win over run edges.
  always_comb begin
    state_d  = state_q;
    wr_d     = 1'b0;
    sel_d    = sel_q;
    data_d   = data_q;
    wl_d     = wl_q;
    cyc_d    = cyc_q;
    budget_d = budget_q;
    err_d    = err_q;
`ifdef LOADER_CHECKSUM_EN
    cs_d     = cs_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (load_rise_q) begin
          state_d = S_LOAD;
          wl_d    = '0;
          err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          cs_d    = '0;
`endif
        end else if (run_rise_q && (wl_q != '0)) begin
          state_d  = S_RUN;
          cyc_d    = '0;
          budget_d = lp.la_run_cycles;
        end
      end
      S_LOAD: begin
        // A strobe coinciding with the release still commits before leaving.
        if (strb_rise_q) begin
          if (wl_q < FULL) begin
            wr_d   = 1'b1;
            sel_d  = wl_q[ADDR_W-1:0];
            data_d = word_q;
            wl_d   = wl_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            cs_d   = {cs_q[30:0], cs_q[31]} ^ word_q;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
        if (load_fall_q) state_d = S_IDLE;
      end
      S_RUN: begin
        cyc_d = cyc_inc;
        if (load_rise_q) begin
          // Abort: a new session restarts at address 0.
          state_d = S_LOAD;
          wl_d    = '0;
          err_d   = 1'b0;
        end else if ((budget_q != '0) && (cyc_inc == budget_q)) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (load_rise_q) begin
          state_d = S_LOAD;
          wl_d    = '0;
          err_d   = 1'b0;
        end else if (run_rise_q) begin
          state_d  = S_RUN;
          cyc_d    = '0;
          budget_d = lp.la_run_cycles;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Core controls follow the next state so they switch on the same edge as state.
    crst_d = (state_d == S_RUN) || (state_d == S_HALT);
    cen_d  = (state_d == S_RUN);
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      sel_q    <= '0;
      data_q   <= '0;
      crst_q   <= 1'b0;
      cen_q    <= 1'b0;
      wl_q     <= '0;
      cyc_q    <= '0;
      budget_q <= '0;
      err_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      cs_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      crst_q   <= crst_d;
      cen_q    <= cen_d;
      wl_q     <= wl_d;
      cyc_q    <= cyc_d;
      budget_q <= budget_d;
      err_q    <= err_d;
`ifdef LOADER_CHECKSUM_EN
      cs_q     <= cs_d;
`endif
    end
  end

  assign lp.iram_write   = wr_q;
  assign lp.iram_select  = sel_q;
  assign lp.iram_data    = data_q;
  assign lp.core_rst_n   = crst_q;
  assign lp.core_clk_en  = cen_q;
  assign lp.state        = state_q;
  assign lp.words_loaded = wl_q;
  assign lp.cycles_run   = cyc_q;
  assign lp.err_overflow = err_q;
`ifdef LOADER_CHECKSUM_EN
  assign lp.checksum     = cs_q;
`endif

endmodule

// File: tb/tb_la_program_loader.sv
// Directed bench for la_program_loader: load, overflow, bounded/free run, abort and async reset.
// Inputs driven and outputs sampled on the falling clock edge.
// Checksum scenario compiled only when LOADER_CHECKSUM_EN is defined.
module tb_la_program_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ntests = 0;
  int   nfail = 0;
  int   en_cnt = 0;
  logic [3:0]  wr_sel[$];
  logic [31:0] wr_dat[$];

  la_program_loader_if #(.ADDR_W(4), .RUN_W(16)) ifc ();

  la_program_loader #(.DEPTH(16), .ADDR_W(4), .RUN_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lp    (ifc)
  );

  always #5 clk = ~clk;

  // Record every write pulse and every enabled core cycle.
  always @(negedge clk) begin
    if (ifc.iram_write === 1'b1) begin
      wr_sel.push_back(ifc.iram_select);
      wr_dat.push_back(ifc.iram_data);
    end
    if (ifc.core_clk_en === 1'b1) en_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifc.la_load_req = 1'b0;
    ifc.la_word_strobe = 1'b0;
    ifc.la_word = '0;
    ifc.la_run_req = 1'b0;
    ifc.la_run_cycles = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    wr_sel.delete();
    wr_dat.delete();
  endtask

  task automatic open_session();
    ifc.la_load_req = 1'b1;
    tick(3);
  endtask

  task automatic close_session();
    ifc.la_load_req = 1'b0;
    tick(3);
  endtask

  task automatic strobe_word(input logic [31:0] w);
    ifc.la_word = w;
    ifc.la_word_strobe = 1'b1;
    tick(2);
    ifc.la_word_strobe = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.la_load_req = 1'b0;
    ifc.la_word_strobe = 1'b0;
    ifc.la_word = '0;
    ifc.la_run_req = 1'b0;
    ifc.la_run_cycles = '0;
    tick(2);
    ntests++; if (ifc.state !== 2'b00) begin nfail++; $display("FAIL reset_state: got %b expected 00", ifc.state); end
    ntests++; if (ifc.iram_write !== 1'b0 || ifc.iram_select !== 4'd0 || ifc.iram_data !== 32'd0) begin
      nfail++; $display("FAIL reset_iram: got w=%b s=%h d=%h expected 0/0/0", ifc.iram_write, ifc.iram_select, ifc.iram_data); end
    ntests++; if (ifc.core_rst_n !== 1'b0 || ifc.core_clk_en !== 1'b0) begin
      nfail++; $display("FAIL reset_core: got rst_n=%b en=%b expected 0/0", ifc.core_rst_n, ifc.core_clk_en); end
    ntests++; if (ifc.words_loaded !== 5'd0 || ifc.cycles_run !== 16'd0 || ifc.err_overflow !== 1'b0) begin
      nfail++; $display("FAIL reset_counters: got wl=%0d cyc=%0d err=%b expected 0/0/0", ifc.words_loaded, ifc.cycles_run, ifc.err_overflow); end
`ifdef LOADER_CHECKSUM_EN
    ntests++; if (ifc.checksum !== 32'd0) begin nfail++; $display("FAIL reset_checksum: got %h expected 0", ifc.checksum); end
`endif
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_load();
    logic [31:0] words [3];
    words[0] = 32'h00500093; words[1] = 32'h00A00113; words[2] = 32'h002081B3;
    do_reset();
    open_session();
    ntests++; if (ifc.state !== 2'b01) begin nfail++; $display("FAIL load_enter: got %b expected 01", ifc.state); end
    // First strobe walked cycle by cycle to pin the k+2 write latency.
    ifc.la_word = words[0];
    ifc.la_word_strobe = 1'b1;
    tick(1);
    ntests++; if (ifc.iram_write !== 1'b0) begin nfail++; $display("FAIL strobe_lat_k: got %b expected 0", ifc.iram_write); end
    tick(1);
    ifc.la_word_strobe = 1'b0;
    ntests++; if (ifc.iram_write !== 1'b0) begin nfail++; $display("FAIL strobe_lat_k1: got %b expected 0", ifc.iram_write); end
    tick(1);
    ntests++; if (ifc.iram_write !== 1'b1 || ifc.iram_select !== 4'd0 || ifc.iram_data !== words[0]) begin
      nfail++; $display("FAIL strobe_lat_k2: got w=%b s=%h d=%h expected 1/0/%h", ifc.iram_write, ifc.iram_select, ifc.iram_data, words[0]); end
    tick(1);
    ntests++; if (ifc.iram_write !== 1'b0) begin nfail++; $display("FAIL strobe_pulse_len: got %b expected 0", ifc.iram_write); end
    strobe_word(words[1]);
    strobe_word(words[2]);
    close_session();
    ntests++; if (wr_sel.size() !== 3) begin nfail++; $display("FAIL load_wr_count: got %0d expected 3", wr_sel.size()); end
    for (int i = 0; i < 3 && i < wr_sel.size(); i++) begin
      ntests++; if (wr_sel[i] !== 4'(i) || wr_dat[i] !== words[i]) begin
        nfail++; $display("FAIL load_wr%0d: got s=%h d=%h expected %h/%h", i, wr_sel[i], wr_dat[i], i, words[i]); end
    end
    ntests++; if (ifc.words_loaded !== 5'd3) begin nfail++; $display("FAIL load_words: got %0d expected 3", ifc.words_loaded); end
    ntests++; if (ifc.state !== 2'b00 || ifc.core_rst_n !== 1'b0) begin
      nfail++; $display("FAIL load_release: got st=%b rst_n=%b expected 00/0", ifc.state, ifc.core_rst_n); end
  endtask

  task automatic test_overflow();
    do_reset();
    open_session();
    for (int i = 0; i < 17; i++) strobe_word(32'hA000_0000 + 32'(i));
    ntests++; if (wr_sel.size() !== 16) begin nfail++; $display("FAIL ovf_wr_count: got %0d expected 16", wr_sel.size()); end
    for (int i = 0; i < 16 && i < wr_sel.size(); i++) begin
      ntests++; if (wr_sel[i] !== 4'(i) || wr_dat[i] !== 32'hA000_0000 + 32'(i)) begin
        nfail++; $display("FAIL ovf_wr%0d: got s=%h d=%h expected %h/%h", i, wr_sel[i], wr_dat[i], i, 32'hA000_0000 + 32'(i)); end
    end
    ntests++; if (ifc.err_overflow !== 1'b1) begin nfail++; $display("FAIL ovf_flag: got %b expected 1", ifc.err_overflow); end
    ntests++; if (ifc.words_loaded !== 5'd16) begin nfail++; $display("FAIL ovf_words: got %0d expected 16", ifc.words_loaded); end
    close_session();
    ntests++; if (ifc.err_overflow !== 1'b1) begin nfail++; $display("FAIL ovf_sticky: got %b expected 1", ifc.err_overflow); end
  endtask

  task automatic test_run_budget();
    do_reset();
    open_session();
    strobe_word(32'h00000013);
    close_session();
    ifc.la_run_cycles = 16'd10;
    en_cnt = 0;
    ifc.la_run_req = 1'b1;
    tick(20);
    ifc.la_run_req = 1'b0;
    ntests++; if (en_cnt !== 10) begin nfail++; $display("FAIL run_en_cycles: got %0d expected 10", en_cnt); end
    ntests++; if (ifc.state !== 2'b11 || ifc.core_rst_n !== 1'b1 || ifc.core_clk_en !== 1'b0) begin
      nfail++; $display("FAIL run_halt: got st=%b rst_n=%b en=%b expected 11/1/0", ifc.state, ifc.core_rst_n, ifc.core_clk_en); end
    ntests++; if (ifc.cycles_run !== 16'd10) begin nfail++; $display("FAIL run_cycles: got %0d expected 10", ifc.cycles_run); end
    // Resume from HALT with a fresh budget.
    tick(2);
    ifc.la_run_cycles = 16'd3;
    en_cnt = 0;
    ifc.la_run_req = 1'b1;
    tick(10);
    ifc.la_run_req = 1'b0;
    ntests++; if (en_cnt !== 3 || ifc.cycles_run !== 16'd3 || ifc.state !== 2'b11) begin
      nfail++; $display("FAIL resume: got en=%0d cyc=%0d st=%b expected 3/3/11", en_cnt, ifc.cycles_run, ifc.state); end
    tick(2);
  endtask

  task automatic test_idle_run();
    do_reset();
    ifc.la_run_req = 1'b1;
    tick(5);
    ifc.la_run_req = 1'b0;
    ntests++; if (ifc.state !== 2'b00) begin nfail++; $display("FAIL idle_run_empty: got %b expected 00", ifc.state); end
    tick(2);
    ifc.la_run_req = 1'b1;
    ifc.la_load_req = 1'b1;
    tick(3);
    ntests++; if (ifc.state !== 2'b01) begin nfail++; $display("FAIL load_beats_run: got %b expected 01", ifc.state); end
    ifc.la_run_req = 1'b0;
    close_session();
  endtask

  task automatic test_free_run_abort();
    do_reset();
    open_session();
    strobe_word(32'h00100093);
    close_session();
    ifc.la_run_cycles = 16'd0;
    ifc.la_run_req = 1'b1;
    tick(3);
    ifc.la_run_req = 1'b0;
    ntests++; if (ifc.state !== 2'b10 || ifc.core_rst_n !== 1'b1 || ifc.core_clk_en !== 1'b1) begin
      nfail++; $display("FAIL free_run_enter: got st=%b rst_n=%b en=%b expected 10/1/1", ifc.state, ifc.core_rst_n, ifc.core_clk_en); end
    tick(30);
    ntests++; if (ifc.state !== 2'b10 || ifc.cycles_run !== 16'd30) begin
      nfail++; $display("FAIL free_run_count: got st=%b cyc=%0d expected 10/30", ifc.state, ifc.cycles_run); end
    ifc.la_load_req = 1'b1;
    tick(2);
    ntests++; if (ifc.state !== 2'b10 || ifc.core_rst_n !== 1'b1) begin
      nfail++; $display("FAIL abort_early: got st=%b rst_n=%b expected 10/1", ifc.state, ifc.core_rst_n); end
    tick(1);
    ntests++; if (ifc.state !== 2'b01 || ifc.core_rst_n !== 1'b0 || ifc.core_clk_en !== 1'b0) begin
      nfail++; $display("FAIL abort_load: got st=%b rst_n=%b en=%b expected 01/0/0", ifc.state, ifc.core_rst_n, ifc.core_clk_en); end
    close_session();
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    open_session();
    ifc.la_word = 32'hDEADBEEF;
    ifc.la_word_strobe = 1'b1;
    tick(2);
    ifc.la_word_strobe = 1'b0;
    tick(1);
    ntests++; if (ifc.iram_write !== 1'b1) begin nfail++; $display("FAIL midwr_pulse: got %b expected 1", ifc.iram_write); end
    #2 rst_n = 1'b0;
    #1;
    ntests++; if (ifc.iram_write !== 1'b0 || ifc.iram_select !== 4'd0 || ifc.iram_data !== 32'd0) begin
      nfail++; $display("FAIL midwr_iram: got w=%b s=%h d=%h expected 0/0/0", ifc.iram_write, ifc.iram_select, ifc.iram_data); end
    ntests++; if (ifc.state !== 2'b00 || ifc.words_loaded !== 5'd0 || ifc.core_rst_n !== 1'b0) begin
      nfail++; $display("FAIL midwr_state: got st=%b wl=%0d rst_n=%b expected 00/0/0", ifc.state, ifc.words_loaded, ifc.core_rst_n); end
    ifc.la_load_req = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    open_session();
    strobe_word(32'h00000001);
    strobe_word(32'h00000002);
    close_session();
    ntests++; if (ifc.checksum !== 32'h00000000) begin nfail++; $display("FAIL checksum_a: got %h expected 00000000", ifc.checksum); end
    open_session();
    strobe_word(32'h80000000);
    ntests++; if (ifc.checksum !== 32'h80000000) begin nfail++; $display("FAIL checksum_b1: got %h expected 80000000", ifc.checksum); end
    strobe_word(32'h00000000);
    close_session();
    ntests++; if (ifc.checksum !== 32'h00000001) begin nfail++; $display("FAIL checksum_b: got %h expected 00000001", ifc.checksum); end
  endtask
`endif

  initial begin
    ifc.la_load_req = 1'b0;
    ifc.la_word_strobe = 1'b0;
    ifc.la_word = '0;
    ifc.la_run_req = 1'b0;
    ifc.la_run_cycles = '0;
    test_reset();
    test_load();
    test_overflow();
    test_run_budget();
    test_idle_run();
    test_free_run_abort();
    test_reset_mid_write();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
